// File: rtl/factorial_ctrl.sv
// factorial_ctrl: control FSM sequencing a register-file datapath to form N!.
// Ports: clk/rst (sync, active-high), start/abort/n_in/sum in; enables, selects, data_in2, busy/done/ovf out.
module factorial_ctrl #(
  parameter int DW    = 16,
  parameter int OVF_N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] n_in,
  input  logic [DW-1:0] sum,
  output logic          we1,
  output logic          we2,
  output logic          wa1,
  output logic [1:0]    wa2,
  output logic          rea1,
  output logic          rea2,
  output logic [1:0]    sel_mux1,
  output logic [1:0]    sel_mux2,
  output logic [DW-1:0] data_in2,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DEC   = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t state, state_nx;

  logic accept;
  assign accept = (state == IDLE) && start;

  // sum is count-1: zero means count==1, all-ones means count==0
  logic last;
  assign last = (sum == '0) || (sum == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_in2 <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_in2 <= n_in;
        ovf      <= (n_in > DW'(OVF_N));
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? INIT : IDLE;
      INIT:    state_nx = CHECK;
      CHECK:   state_nx = last ? FIN : MULT;
      MULT:    state_nx = DEC;
      DEC:     state_nx = CHECK;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort beats every transition except from IDLE
    if (abort && state != IDLE) state_nx = IDLE;
  end

  always_comb begin
    we1      = 1'b0;
    we2      = 1'b0;
    wa1      = 1'b0;
    wa2      = 2'b00;
    rea1     = 1'b0;
    rea2     = 1'b0;
    sel_mux1 = 2'd0;
    sel_mux2 = 2'd0;
    done     = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      INIT: begin
        we1      = 1'b1;
        sel_mux1 = 2'd2;
        we2      = 1'b1;
        wa2      = 2'b01;
        sel_mux2 = 2'd0;
      end
      CHECK: begin
        rea1 = 1'b1;
        rea2 = 1'b1;
      end
      MULT: begin
        rea1     = 1'b1;
        rea2     = 1'b1;
        we1      = 1'b1;
        sel_mux1 = 2'd1;
      end
      DEC: begin
        rea2     = 1'b1;
        we2      = 1'b1;
        wa2      = 2'b01;
        sel_mux2 = 2'd1;
      end
      FIN: begin
        done = 1'b1;
        rea1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: drives factorial_ctrl with a behavioural datapath attached.
// Results are pushed to a scoreboard at START and checked at each DONE pulse.
module tb_factorial_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] n_in, sum;
  logic        we1, we2, wa1, rea1, rea2, busy, done, ovf;
  logic [1:0]  wa2, sel_mux1, sel_mux2;
  logic [15:0] data_in2;

  always #5 clk = ~clk;

  factorial_ctrl #(.DW(16), .OVF_N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_in(n_in), .sum(sum), .we1(we1), .we2(we2), .wa1(wa1),
    .wa2(wa2), .rea1(rea1), .rea2(rea2), .sel_mux1(sel_mux1),
    .sel_mux2(sel_mux2), .data_in2(data_in2), .busy(busy),
    .done(done), .ovf(ovf)
  );

  // datapath: accumulator at address 0, counter at address 1
  logic [15:0] acc, cnt;
  assign sum = cnt + 16'hFFFF;
  always @(posedge clk) begin
    if (we1 && !wa1) begin
      if (sel_mux1 == 2'd2) acc <= 16'd1;
      else if (sel_mux1 == 2'd1) acc <= acc * cnt;
    end
    if (we2 && wa2 == 2'b01) begin
      if (sel_mux2 == 2'd0) cnt <= data_in2;
      else if (sel_mux2 == 2'd1) cnt <= cnt - 16'd1;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
    int          mults;
  } exp_t;

  exp_t sb[$];

  // cycle 1 is the cycle after the edge that accepts START
  int cyc, mults;
  always @(posedge clk) begin
    if (!rst && start && !busy) begin
      cyc   <= 1;
      mults <= 0;
    end else begin
      cyc <= cyc + 1;
      if (we1 && sel_mux1 == 2'd1) mults <= mults + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && (!busy || done)) chk("no_write_idle_fin", {30'd0, we1, we2}, 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", acc, e.res);
        chk("ovf_at_done", ovf, e.ovf);
        chk("latency", cyc, e.lat);
        chk("mult_cycles", mults, e.mults);
      end
    end
  end

  task automatic go(logic [15:0] n, logic push);
    exp_t e;
    logic [15:0] f;
    f = 16'd1;
    for (int k = 2; k <= int'(n); k++) f = f * 16'(k);
    e.res   = f;
    e.ovf   = (n > 16'd8);
    e.lat   = 3 * ((n > 16'd1) ? int'(n) : 1);
    e.mults = (n > 16'd1) ? int'(n) - 1 : 0;
    @(negedge clk);
    start = 1'b1;
    n_in  = n;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= 200) chk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0].n = 16'd5;
    vecs[1].n = 16'd0;
    vecs[2].n = 16'd1;
    vecs[3].n = 16'd9;
    vecs[4].n = 16'd8;
    vecs[5].n = 16'd2;
    vecs[6].n = 16'd3;

    rst = 1'b1; start = 1'b0; abort = 1'b0; n_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_data_in2", data_in2, 32'd0);
    chk("rst_we", {we1, we2}, 32'd0);

    // first START right as reset drops
    rst   = 1'b0;
    start = 1'b1;
    n_in  = 16'd6;
    sb.push_back('{res: 16'd720, ovf: 1'b0, lat: 18, mults: 5});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("first_start_busy", busy, 1'b1);
    wait_done();

    for (int i = 0; i < 7; i++) begin
      go(vecs[i].n, 1'b1);
      @(negedge clk);
      chk("ovf_cycle1", ovf, (vecs[i].n > 16'd8));
      chk("data_in2", data_in2, vecs[i].n);
      wait_done();
    end

    // START N=3 while busy with N=5 is ignored
    go(16'd5, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    n_in  = 16'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_hold_data", data_in2, 32'd5);
    wait_done();
    chk("busy_hold_after", data_in2, 32'd5);

    // ABORT in cycle 7 of an N=5 run
    go(16'd5, 1'b0);
    while (cyc < 7) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    go(16'd4, 1'b1);
    wait_done();

    // ABORT alone in IDLE does nothing; START+ABORT in IDLE starts
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_noop", busy, 1'b0);
    start = 1'b1;
    n_in  = 16'd2;
    sb.push_back('{res: 16'd2, ovf: 1'b0, lat: 6, mults: 1});
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    wait_done();

    // RST during a MULT cycle of an overflowing run
    go(16'd9, 1'b0);
    begin
      int k;
      k = 0;
      while (!(we1 && sel_mux1 == 2'd1) && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("reach_mult", {31'd0, we1}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_data", data_in2, 32'd0);
    chk("mid_rst_outs",
        {we1, we2, wa1, wa2, rea1, rea2, sel_mux1, sel_mux2, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/factorial_ctrl.md
FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, meaning datapath word width.
REQ-002 SHALL have parameter OVF_N, default 8, meaning largest N whose factorial fits in DW bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  request to compute N_IN!; honoured only in IDLE.
REQ-006 ABORT  input  1  cancel the computation in progress.
REQ-007 N_IN  input  DW  operand N, sampled when START is accepted.
REQ-008 SUM  input  DW  datapath count-minus-one status (count + 16'hFFFF).
REQ-009 WE1, WE2  output  1 each  register-file write enables (accumulator, counter).
REQ-010 WA1  output  1  accumulator write address; WA2  output  2  counter write address.
REQ-011 REA1, REA2  output  1 each  register-file read enables.
REQ-012 SEL_MUX1, SEL_MUX2  output  2 each  datapath mux selects.
REQ-013 DATA_IN2  output  DW  registered copy of N, fed to datapath mux 2 input 0.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 OVF  output  1  sticky flag: the accepted N exceeds OVF_N.

Function
REQ-017 The FSM SHALL have the states IDLE, INIT, CHECK, MULT, DEC and FIN, encoded as a registered state.
REQ-018 IDLE SHALL drive all control outputs to 0; START=1 -> latch N_IN into DATA_IN2, set OVF=(N_IN>OVF_N), go to INIT.
REQ-019 INIT SHALL drive WE1=1, WA1=0, SEL_MUX1=2 (accumulator<=1) and WE2=1, WA2=2'b01, SEL_MUX2=0 (counter<=N) in the same cycle, then go to CHECK.
REQ-020 CHECK SHALL drive REA1=REA2=1, no writes.
  - SUM==0 or SUM==all-ones (counter<=1) -> FIN.
  - Otherwise -> MULT.
REQ-021 MULT SHALL drive REA1=REA2=1, WE1=1, WA1=0, SEL_MUX1=1 (accumulator<=accumulator*counter), then go to DEC.
REQ-022 DEC SHALL drive REA2=1, WE2=1, WA2=2'b01, SEL_MUX2=1 (counter<=counter-1), then go to CHECK.
REQ-023 FIN SHALL assert DONE=1 and REA1=1 for exactly one cycle, then go to IDLE; BUSY=0 in the following cycle.
REQ-024 Control outputs SHALL be a combinational decode of the state only; WE1/WE2 SHALL never be high in IDLE or FIN.
REQ-025 Latency: with START sampled at edge 0, DONE SHALL be high in cycle 3*max(N,1).
REQ-026 START while BUSY SHALL be ignored; DATA_IN2 and OVF SHALL be held.
REQ-027 ABORT in any non-IDLE state SHALL force IDLE on the next edge with no DONE pulse.
  - ABORT has priority over state transitions.
  - In IDLE, ABORT SHALL have no effect.
REQ-028 Simultaneous START and ABORT in IDLE: START SHALL win.
REQ-029 OVF SHALL NOT change the sequence; the datapath product wraps mod 2^DW.
  - OVF is cleared only at the next accepted START or at RST.
REQ-030 No state SHALL be unreachable.
  - Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-031 RST=1 at an edge SHALL set state=IDLE, DATA_IN2=0, OVF=0, DONE=0 and BUSY=0, with all write enables low in the next cycle.
REQ-032 RST SHALL override START and ABORT, including when asserted mid-computation.
REQ-033 The first START SHALL be accepted at the first edge after RST deasserts.

Verification
REQ-034 N=5, datapath attached -> DONE high in cycle 15; accumulator=120; OVF=0; exactly 4 MULT and 4 DEC cycles.
REQ-035 N=0 and N=1 -> DONE in cycle 3; accumulator=1; no MULT cycle.
REQ-036 N=9 -> OVF=1 from cycle 1; DONE in cycle 27; accumulator=362880 mod 65536=35200.
REQ-037 START pulse with N=3 during a busy N=5 run -> ignored; DATA_IN2 stays 5; result 120.
REQ-038 ABORT in cycle 7 of an N=5 run -> IDLE at cycle 8; no DONE; a new START with N=4 then yields 24 in cycle 12.
REQ-039 RST asserted in a MULT cycle -> the next cycle shows IDLE with all outputs 0 and OVF=0.
